// File: rtl/onehot_demux_buf_pkg.sv
// Shared constants and lane-slice helper for the tile return-path demux.
// The merge mux reuses lane_lo so both sides agree on lane packing.
package onehot_demux_buf_pkg;

  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 2;

  function automatic int unsigned lane_lo(
    input int unsigned j,
    input int unsigned dw
  );
    return j * dw;
  endfunction

endpackage

// File: rtl/onehot_demux_buf_fifo_reg.sv
// Register FIFO with push/pop/count; count, not pointer compare,
// tells full from empty. Storage is not reset.
module onehot_demux_buf_fifo_reg
  import onehot_demux_buf_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = DEPTH_DEF,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  // Depth is a power of two, so natural pointer overflow wraps to 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + PtrW'(1);
      if (pop_i)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rptr];
  assign count_o = r_count;

endmodule

// File: rtl/onehot_demux_buf.sv
// Buffered one-hot demux: steers each accepted beat to one output lane.
// Illegal selects are consumed, dropped and flagged on err_o.
module onehot_demux_buf
  import onehot_demux_buf_pkg::*;
#(
  parameter int unsigned OutputWidth = OUT_W_DEF,
  parameter int unsigned DataWidth   = DATA_W_DEF,
  parameter int unsigned Depth       = DEPTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [OutputWidth-1:0]         in_sel_i,
  input  logic [DataWidth-1:0]           in_data_i,
  output logic [OutputWidth-1:0]         out_valid_o,
  input  logic [OutputWidth-1:0]         out_ready_i,
  output logic [OutputWidth*DataWidth-1:0] out_data_o,
  output logic                           err_o
);

  localparam int unsigned EntW = OutputWidth + DataWidth;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic                   w_accept;
  logic                   w_legal;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_nonempty;
  logic [EntW-1:0]        w_head;
  logic [OutputWidth-1:0] w_head_sel;
  logic [DataWidth-1:0]   w_head_data;
  logic [CntW-1:0]        w_count;
  logic                   r_err;

  assign in_ready_o = (w_count < CntW'(Depth));
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_legal    = $onehot(in_sel_i);
  assign w_push     = w_accept & w_legal;
  assign w_pop      = |(out_valid_o & out_ready_i);

  onehot_demux_buf_fifo_reg #(
    .Width (EntW),
    .Depth (Depth),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i ({in_sel_i, in_data_i}),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= w_accept & ~w_legal;
  end

  assign err_o       = r_err;
  assign w_nonempty  = (w_count != '0);
  assign w_head_sel  = w_head[DataWidth +: OutputWidth];
  assign w_head_data = w_head[DataWidth-1:0];
  assign out_valid_o = w_nonempty ? w_head_sel : '0;

  for (genvar j = 0; j < OutputWidth; j++) begin : g_lane
    localparam int unsigned Lo = lane_lo(j, DataWidth);
    assign out_data_o[Lo +: DataWidth] =
      out_valid_o[j] ? w_head_data : '0;
  end

endmodule
